control_sequencer: RTL and testbench

Sequential core of the control unit. It holds the instruction-step state register and an instruction latch for multi-cycle instructions, and classifies the current opcode. It selects one per-instruction decoder control word, such as the MOVK decoder's, from a flattened bus. It also applies memory stalls, halt and illegal-opcode trapping, and counts retired instructions. It sits between instruction memory and the `IW_decoder_*` modules, and its `cw` output drives the datapath.

---
 rtl/ctrl_pkg.sv | 62 ++++++
 rtl/opcode_classifier.sv | 34 +++
 rtl/control_sequencer.sv | 110 +++++++++++
 tb/tb_control_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the control sequencer slice.
//   - control-word width and field positions
//   - opcode class codes (cls_e)
//   - opcode pattern constants used by the classifier
//   - NOP control word and the HALT instruction encoding
package ctrl_pkg;

  localparam int unsigned CW_W = 33;

  // Control-word field positions
  localparam int unsigned F_NS_LSB     = 0;   // next_state[1:0]
  localparam int unsigned F_NS_W       = 2;
  localparam int unsigned F_STATUS_LD  = 2;
  localparam int unsigned F_PC_IS      = 3;
  localparam int unsigned F_PC_FS_LSB  = 4;   // pc_fs[5:4]
  localparam int unsigned F_PC_FS_W    = 2;
  localparam int unsigned F_RAM_W      = 6;
  localparam int unsigned F_RAM_EN     = 7;
  localparam int unsigned F_RF_W       = 8;
  localparam int unsigned F_RF_DA_LSB  = 9;   // rf_da[13:9]
  localparam int unsigned F_RF_SB_LSB  = 14;  // rf_sb[18:14]
  localparam int unsigned F_RF_SA_LSB  = 19;  // rf_sa[23:19]
  localparam int unsigned F_RF_REG_W   = 5;
  localparam int unsigned F_RF_B_EN    = 24;
  localparam int unsigned F_ALU_FS_LSB = 25;  // alu_fs[29:25]
  localparam int unsigned F_ALU_FS_W   = 5;
  localparam int unsigned F_ALU_BS     = 30;
  localparam int unsigned F_ALU_EN     = 31;
  localparam int unsigned F_RSVD       = 32;

  typedef enum logic [2:0] {
    CLS_RALU = 3'd0,
    CLS_IALU = 3'd1,
    CLS_DMEM = 3'd2,
    CLS_B    = 3'd3,
    CLS_CB   = 3'd4,
    CLS_MOVZ = 3'd5,
    CLS_MOVK = 3'd6,
    CLS_TRAP = 3'd7
  } cls_e;

  // Opcode patterns
  localparam logic [8:0]  OP_MOVK   = 9'b111100101;   // ir[31:23]
  localparam logic [8:0]  OP_MOVZ   = 9'b110100101;   // ir[31:23]
  localparam logic [10:0] OP_LDUR   = 11'b11111000010; // ir[31:21]
  localparam logic [10:0] OP_STUR   = 11'b11111000000; // ir[31:21]
  localparam logic [5:0]  OP_B      = 6'b000101;      // ir[31:26]
  localparam logic [7:0]  OP_CBZ    = 8'b10110100;    // ir[31:24]
  localparam logic [7:0]  OP_CBNZ   = 8'b10110101;    // ir[31:24]
  localparam logic [7:0]  OP_BCOND  = 8'b01010100;    // ir[31:24]
  localparam logic [4:0]  OP_IALU_A = 5'b10001;       // ir[28:24]
  localparam logic [4:0]  OP_IALU_B = 5'b10010;       // ir[28:24]
  localparam logic [4:0]  OP_RALU_A = 5'b01010;       // ir[28:24]
  localparam logic [4:0]  OP_RALU_B = 5'b01011;       // ir[28:24]
  localparam logic [10:0] OP_LSL    = 11'b11010011011; // ir[31:21]
  localparam logic [10:0] OP_LSR    = 11'b11010011010; // ir[31:21]

  // NOP: everything off, register selects parked on X31
  localparam logic [32:0] NOP_CW    = 33'h0_00FF_FE00;
  localparam logic [31:0] HALT_INSN = 32'h0;

endpackage

// File: rtl/opcode_classifier.sv
// opcode_classifier: combinational opcode class decode (first match wins).
//   ir      in  32  instruction being executed
//   cls     out 3   opcode class (CLS_TRAP for anything unrecognised)
//   is_halt out 1   instruction is the HALT encoding
module opcode_classifier
  import ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output cls_e        cls,
  output logic        is_halt
);

  always_comb begin
    is_halt = (ir == HALT_INSN);
    if (ir[31:23] == OP_MOVK)
      cls = CLS_MOVK;
    else if (ir[31:23] == OP_MOVZ)
      cls = CLS_MOVZ;
    else if (ir[31:21] == OP_LDUR || ir[31:21] == OP_STUR)
      cls = CLS_DMEM;
    else if (ir[31:26] == OP_B)
      cls = CLS_B;
    else if (ir[31:24] == OP_CBZ || ir[31:24] == OP_CBNZ || ir[31:24] == OP_BCOND)
      cls = CLS_CB;
    else if (ir[28:24] == OP_IALU_A || ir[28:24] == OP_IALU_B)
      cls = CLS_IALU;
    else if (ir[28:24] == OP_RALU_A || ir[28:24] == OP_RALU_B ||
             ir[31:21] == OP_LSL    || ir[31:21] == OP_LSR)
      cls = CLS_RALU;
    else
      cls = CLS_TRAP;
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: sequential core of the control unit.
//   clock    in  1                   rising-edge clock
//   reset_n  in  1                   asynchronous active-low reset
//   I        in  32                  instruction word at current PC
//   cw_bus   in  NUM_CLASSES*CW_W    decoder control words, slot k at [k*CW_W +: CW_W]
//   mem_busy in  1                   RAM not ready
//   cw       out CW_W                control word to datapath (bit 32 always 0)
//   state    out 2                   step state fed to decoders
//   ir       out 32                  instruction fed to decoders
//   cls      out 3                   current opcode class
//   halted   out 1                   sequencer stopped (left only by reset)
//   illegal  out 1                   sticky illegal-opcode flag
//   retired  out 32                  completed-instruction count (wraps)
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = 8,
  parameter int unsigned CW_W        = 33
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [31:0]                 I,
  input  logic [NUM_CLASSES*CW_W-1:0] cw_bus,
  input  logic                        mem_busy,
  output logic [CW_W-1:0]             cw,
  output logic [1:0]                  state,
  output logic [31:0]                 ir,
  output logic [2:0]                  cls,
  output logic                        halted,
  output logic                        illegal,
  output logic [31:0]                 retired
);

  logic [31:0]     ir_q;
  cls_e            cls_w;
  logic            is_halt;
  logic [CW_W-1:0] slot;
  logic [CW_W-1:0] sel;
  logic            stall;
  logic            commit;

  assign ir  = (state == 2'b00) ? I : ir_q;
  assign cls = cls_w;

  opcode_classifier u_classifier (
    .ir      (ir),
    .cls     (cls_w),
    .is_halt (is_halt)
  );

  always_comb begin
    slot = '0;
    for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
      if (3'(k) == cls_w)
        slot = cw_bus[k*CW_W +: CW_W];
    end
  end

  // Class 7 ignores its slot; a decoder next_state of 11 folds to 00 so
  // the datapath and the state register see the same value.
  always_comb begin
    sel = (cls_w == CLS_TRAP) ? CW_W'(NOP_CW) : slot;
    if (sel[F_NS_LSB +: F_NS_W] == 2'b11)
      sel[F_NS_LSB +: F_NS_W] = 2'b00;
  end

  assign stall  = !halted && (sel[F_RAM_EN] || sel[F_RAM_W]) && mem_busy;
  assign commit = !halted && !stall;

  // While stalled the RAM strobes stay up but every architectural update
  // is suppressed, including the step-state advance.
  always_comb begin
    if (halted) begin
      cw = CW_W'(NOP_CW);
    end else begin
      cw         = sel;
      cw[F_RSVD] = 1'b0;
      if (stall) begin
        cw[F_RF_W]                    = 1'b0;
        cw[F_PC_FS_LSB +: F_PC_FS_W]  = 2'b00;
        cw[F_STATUS_LD]               = 1'b0;
        cw[F_NS_LSB +: F_NS_W]        = state;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= 2'b00;
      ir_q    <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
      retired <= '0;
    end else if (commit) begin
      if (state == 2'b00)
        ir_q <= I;
      if (cls_w == CLS_TRAP) begin
        halted <= 1'b1;
        if (!is_halt)
          illegal <= 1'b1;
        state <= 2'b00;
      end else begin
        state <= sel[F_NS_LSB +: F_NS_W];
        if (sel[F_NS_LSB +: F_NS_W] == 2'b00)
          retired <= retired + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed self-checking bench for control_sequencer.
module tb_control_sequencer;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [31:0]    I;
  logic [263:0]   cw_bus;
  logic           mem_busy;
  logic [32:0]    cw;
  logic [1:0]     state;
  logic [31:0]    ir;
  logic [2:0]     cls;
  logic           halted;
  logic           illegal;
  logic [31:0]    retired;

  int total = 0;
  int bad   = 0;

  localparam logic [32:0] NOP = 33'h0_00FF_FE00;

  control_sequencer #(.NUM_CLASSES(8), .CW_W(33)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .I        (I),
    .cw_bus   (cw_bus),
    .mem_busy (mem_busy),
    .cw       (cw),
    .state    (state),
    .ir       (ir),
    .cls      (cls),
    .halted   (halted),
    .illegal  (illegal),
    .retired  (retired)
  );

  always #5 clock = ~clock;

  // Builds a control word from the fields the bench exercises; rf_da fixed at 3.
  function automatic logic [32:0] mk(input logic [1:0] ns, input logic sld,
                                     input logic [1:0] pcfs, input logic ramen,
                                     input logic ramw, input logic rfw,
                                     input logic aluen);
    logic [32:0] w;
    w = '0;
    w[1:0]  = ns;
    w[2]    = sld;
    w[5:4]  = pcfs;
    w[6]    = ramw;
    w[7]    = ramen;
    w[8]    = rfw;
    w[13:9] = 5'd3;
    w[31]   = aluen;
    return w;
  endfunction

  // Stand-in decoders: MOVK is two steps, everything else one.
  always_comb begin
    cw_bus = '0;
    cw_bus[0*33 +: 33] = mk(2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1) | 33'h1_0000_0000;
    cw_bus[2*33 +: 33] = mk(2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
    cw_bus[6*33 +: 33] = mk((state == 2'b00) ? 2'b01 : 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    cw_bus[7*33 +: 33] = '1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] junk [3];
    junk[0] = 32'hFFFFFFFF;
    junk[1] = 32'hF2A00021;
    junk[2] = 32'hF8400000;

    reset_n = 1'b0; I = 32'hF2A00021; mem_busy = 1'b0;
    #2;
    chk("rst_state",   64'(state),   64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    chk("rst_halted",  64'(halted),  64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    chk("rst_ir",      64'(ir),      64'hF2A00021);
    @(negedge clock); reset_n = 1'b1; #1;

    // MOVK: two steps, ir latched through step 01
    chk("movk_cls0", 64'(cls),   64'd6);
    chk("movk_st0",  64'(state), 64'd0);
    chk("movk_cw0",  64'(cw),    64'(mk(2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0)));
    step();
    chk("movk_st1",  64'(state), 64'd1);
    I = 32'hDEADBEEF; #1;
    chk("movk_ir1",  64'(ir),      64'hF2A00021);
    chk("movk_cls1", 64'(cls),     64'd6);
    chk("movk_ret1", 64'(retired), 64'd0);
    I = 32'hF8400000; mem_busy = 1'b1;
    step();
    chk("movk_st2",  64'(state),   64'd0);
    chk("movk_ret2", 64'(retired), 64'd1);

    // LDUR with three busy cycles
    chk("ldur_cls", 64'(cls), 64'd2);
    for (int i = 0; i < 3; i++) begin
      chk("ldur_stall_cw",  64'(cw),      64'(mk(2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0)));
      step();
      chk("ldur_stall_st",  64'(state),   64'd0);
      chk("ldur_stall_ret", 64'(retired), 64'd1);
    end
    mem_busy = 1'b0; #1;
    chk("ldur_go_cw", 64'(cw), 64'(mk(2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0)));
    step();
    chk("ldur_ret", 64'(retired), 64'd2);

    // Retire counter wrap on an ADD; reserved bit 32 must not reach cw
    I = 32'h8B020020; #1;
    chk("add_cls", 64'(cls), 64'd0);
    chk("add_cw",  64'(cw),  64'(mk(2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1)));
    force dut.retired = 32'hFFFFFFFF;
    #1;
    release dut.retired;
    step();
    chk("wrap_ret", 64'(retired), 64'd0);

    // HALT
    I = 32'h0; #1;
    chk("halt_cls", 64'(cls), 64'd7);
    chk("halt_cw0", 64'(cw),  64'(NOP));
    step();
    chk("halt_h",   64'(halted),  64'd1);
    chk("halt_ill", 64'(illegal), 64'd0);
    for (int i = 0; i < 3; i++) begin
      I = junk[i]; mem_busy = 1'b1; #1;
      chk("halt_cw",  64'(cw), 64'(NOP));
      step();
      chk("halt_ret", 64'(retired), 64'd0);
      chk("halt_st",  64'(state),   64'd0);
      chk("halt_ill2", 64'(illegal), 64'd0);
    end
    mem_busy = 1'b0;

    // Illegal opcode, then asynchronous clear
    reset_n = 1'b0; #1;
    chk("ill_pre_h", 64'(halted), 64'd0);
    reset_n = 1'b1;
    I = 32'hFFFFFFFF;
    step();
    chk("ill_h",   64'(halted),  64'd1);
    chk("ill_ill", 64'(illegal), 64'd1);
    #2; reset_n = 1'b0; #1;
    chk("ill_clr_h",   64'(halted),  64'd0);
    chk("ill_clr_ill", 64'(illegal), 64'd0);
    reset_n = 1'b1;

    // Reset in the middle of a MOVK
    I = 32'h8B020020;
    step();
    chk("mid_pre_ret", 64'(retired), 64'd1);
    I = 32'hF2A00021;
    step();
    chk("mid_st1", 64'(state), 64'd1);
    #2; reset_n = 1'b0; #1;
    chk("mid_rst_st",  64'(state),   64'd0);
    chk("mid_rst_ret", 64'(retired), 64'd0);
    reset_n = 1'b1;
    I = 32'h8B020020; #1;
    chk("mid_ir",  64'(ir),  64'h8B020020);
    chk("mid_cls", 64'(cls), 64'd0);
    step();
    chk("mid_ret", 64'(retired), 64'd1);
    chk("mid_st",  64'(state),   64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
